// File: rtl/core_pipe_fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: fetch granule size, the
// controller state encoding and the fill-size encoding driven by the
// halfword offset into the first fetched granule after a redirect.
package core_pipe_fetch_ctrl_pkg;

  localparam int CORE_FETCH_BYTES = 8;

  typedef enum logic [1:0] {
    FC_BOOT = 2'd0,
    FC_RUN  = 2'd1,
    FC_STOP = 2'd2
  } fc_state_e;

  // Encoded so that the value equals the halfword offset that produces it.
  typedef enum logic [1:0] {
    FILL_8 = 2'd0,
    FILL_6 = 2'd1,
    FILL_4 = 2'd2,
    FILL_2 = 2'd3
  } fill_size_e;

  function automatic fill_size_e fill_size_from_offset(input logic [1:0] offset);
    return fill_size_e'(offset);
  endfunction

endpackage

// File: rtl/core_pipe_fetch_align.sv
// Response aligner: turns a 64-bit fetch response plus the halfword offset
// of the first useful instruction byte into a one-hot fill-size strobe and
// right-aligned fill data. Purely combinational.
//
// Ports:
//   en      in   response is to be written into the buffer this cycle
//   offset  in   halfword offset of the first useful halfword (0..3)
//   rdata   in   raw 64-bit response data
//   fill_2/4/6/8 out  one-hot fill-size strobe, all zero when en=0
//   data    out  rdata shifted right by 16*offset, zero when en=0
module core_pipe_fetch_align
  import core_pipe_fetch_ctrl_pkg::*;
(
  input  logic        en,
  input  logic [1:0]  offset,
  input  logic [63:0] rdata,
  output logic        fill_2,
  output logic        fill_4,
  output logic        fill_6,
  output logic        fill_8,
  output logic [63:0] data
);

  fill_size_e size;

  always_comb begin
    size   = fill_size_from_offset(offset);
    fill_2 = en && (size == FILL_2);
    fill_4 = en && (size == FILL_4);
    fill_6 = en && (size == FILL_6);
    fill_8 = en && (size == FILL_8);
    data   = en ? (rdata >> {offset, 4'b0000}) : 64'd0;
  end

endmodule

// File: rtl/core_pipe_fetch_ctrl.sv
// Fetch sequencer between the instruction memory bus and the 12-byte fetch
// buffer. Issues 8-byte aligned requests when buffer space can be reserved,
// aligns responses into buffer fills, flushes on redirect while discarding
// stale in-flight responses, and halts fetching after a bus error.
//
// state | meaning
// BOOT  | one cycle after reset, no request issued
// RUN   | requests issued whenever space is reserved
// STOP  | bus error seen, no new requests until the next redirect
//
// Ports:
//   g_clk, g_resetn            clock, synchronous active-low reset
//   imem_req/gnt/addr          request handshake, addr 8-byte aligned
//   imem_recv/ack/rdata/error  response handshake, ack always 1
//   cf_req/target/ack          redirect, accepted in the cycle it is seen
//   buf_depth, buf_drain_bytes buffer occupancy and this cycle's drain
//   buf_flush, buf_fill_*      buffer flush, fill enable and size strobes
//   buf_data, buf_error        right-aligned fill data and error tag
module core_pipe_fetch_ctrl
  import core_pipe_fetch_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC        = 64'h0000_0000_8000_0000,
  parameter int          BUF_BYTES       = 12,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  output logic        imem_req,
  input  logic        imem_gnt,
  output logic [63:0] imem_addr,
  input  logic        imem_recv,
  output logic        imem_ack,
  input  logic [63:0] imem_rdata,
  input  logic        imem_error,
  input  logic        cf_req,
  input  logic [63:0] cf_target,
  output logic        cf_ack,
  input  logic [4:0]  buf_depth,
  output logic        buf_flush,
  output logic        buf_fill_en,
  output logic        buf_fill_2,
  output logic        buf_fill_4,
  output logic        buf_fill_6,
  output logic        buf_fill_8,
  output logic [63:0] buf_data,
  output logic        buf_error,
  input  logic [2:0]  buf_drain_bytes
);

  localparam logic [5:0] BUF_LIMIT = 6'(BUF_BYTES);
  localparam logic [1:0] MAX_OUT   = 2'(MAX_OUTSTANDING);
  localparam logic [63:0] FETCH_STEP = 64'(CORE_FETCH_BYTES);

  fc_state_e   state_q, state_d;
  logic [63:0] fetch_addr_q;
  logic [63:0] req_addr_q;
  logic [1:0]  offset_q;
  logic [1:0]  outstanding_q, outstanding_d;
  logic [1:0]  discard_q, discard_d;
  logic        req_hold_q;
  logic        pending_stale_q;

  logic        req_new;
  logic        gnt_acc;
  logic        recv_acc;
  logic        fill_active;
  logic [2:0]  outstanding_p1;
  logic [5:0]  space_need;
  logic        cf_target_unused;

  assign cf_target_unused = cf_target[0];

  // Space needed if one more request is granted: what stays after this
  // cycle's drain plus a full granule for every in-flight request.
  assign outstanding_p1 = {1'b0, outstanding_q} + 3'd1;
  assign space_need     = {1'b0, buf_depth} - {3'b000, buf_drain_bytes}
                        + {outstanding_p1, 3'b000};

  assign req_new = (state_q == FC_RUN) && !req_hold_q
                && (space_need <= BUF_LIMIT) && (outstanding_q < MAX_OUT);

  // A request once raised stays up with its original address until granted,
  // even if a redirect or error happens meanwhile.
  assign imem_req  = req_hold_q | req_new;
  assign imem_addr = req_hold_q ? req_addr_q : fetch_addr_q;
  assign imem_ack  = 1'b1;

  assign cf_ack    = cf_req;
  assign buf_flush = cf_req;

  assign gnt_acc  = imem_req & imem_gnt;
  assign recv_acc = imem_recv;

  assign fill_active = recv_acc && (discard_q == 2'd0) && !cf_req;
  assign buf_fill_en = fill_active;
  assign buf_error   = fill_active & imem_error;

  core_pipe_fetch_align u_align (
    .en     (fill_active),
    .offset (offset_q),
    .rdata  (imem_rdata),
    .fill_2 (buf_fill_2),
    .fill_4 (buf_fill_4),
    .fill_6 (buf_fill_6),
    .fill_8 (buf_fill_8),
    .data   (buf_data)
  );

  always_ff @(posedge g_clk) begin
    if (!g_resetn) state_q <= FC_BOOT;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FC_BOOT: state_d = FC_RUN;
      FC_RUN:  if (fill_active && imem_error) state_d = FC_STOP;
      FC_STOP: state_d = FC_STOP;
      default: state_d = FC_BOOT;
    endcase
    if (cf_req) state_d = FC_RUN;
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (gnt_acc && !recv_acc)      outstanding_d = outstanding_q + 2'd1;
    else if (!gnt_acc && recv_acc) outstanding_d = outstanding_q - 2'd1;

    // On redirect everything still in flight next cycle is stale. A stale
    // pending request joins the discard count only once it is granted.
    discard_d = discard_q;
    if (cf_req) begin
      discard_d = outstanding_d;
    end else begin
      if (recv_acc && (discard_q != 2'd0)) discard_d = discard_d - 2'd1;
      if (gnt_acc && pending_stale_q)      discard_d = discard_d + 2'd1;
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      fetch_addr_q    <= {RESET_PC[63:3], 3'b000};
      offset_q        <= RESET_PC[2:1];
      req_addr_q      <= 64'd0;
      req_hold_q      <= 1'b0;
      pending_stale_q <= 1'b0;
      outstanding_q   <= 2'd0;
      discard_q       <= 2'd0;
    end else begin
      req_hold_q    <= imem_req & ~imem_gnt;
      req_addr_q    <= imem_addr;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      if (cf_req) begin
        fetch_addr_q    <= {cf_target[63:3], 3'b000};
        offset_q        <= cf_target[2:1];
        pending_stale_q <= imem_req & ~imem_gnt;
      end else begin
        // fetch_addr already points at the redirect target when a stale
        // request is granted, so only fresh grants advance it.
        if (gnt_acc && !pending_stale_q) fetch_addr_q <= fetch_addr_q + FETCH_STEP;
        if (gnt_acc)                     pending_stale_q <= 1'b0;
        if (fill_active)                 offset_q <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_core_pipe_fetch_ctrl.sv
module tb_core_pipe_fetch_ctrl;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        imem_req, imem_gnt, imem_recv, imem_ack, imem_error;
  logic [63:0] imem_addr, imem_rdata;
  logic        cf_req, cf_ack;
  logic [63:0] cf_target;
  logic [4:0]  buf_depth;
  logic        buf_flush, buf_fill_en, buf_fill_2, buf_fill_4, buf_fill_6, buf_fill_8;
  logic [63:0] buf_data;
  logic        buf_error;
  logic [2:0]  buf_drain_bytes;

  core_pipe_fetch_ctrl #(.RESET_PC(RESET_PC), .BUF_BYTES(12), .MAX_OUTSTANDING(2)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_addr(imem_addr),
    .imem_recv(imem_recv), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_error(imem_error),
    .cf_req(cf_req), .cf_target(cf_target), .cf_ack(cf_ack),
    .buf_depth(buf_depth), .buf_flush(buf_flush), .buf_fill_en(buf_fill_en),
    .buf_fill_2(buf_fill_2), .buf_fill_4(buf_fill_4), .buf_fill_6(buf_fill_6), .buf_fill_8(buf_fill_8),
    .buf_data(buf_data), .buf_error(buf_error), .buf_drain_bytes(buf_drain_bytes)
  );

  always #5 g_clk = ~g_clk;

  typedef struct { logic [63:0] addr; int ep; logic err; int ready; } flight_t;
  typedef struct { int size; logic [63:0] data; logic err; } fill_t;

  flight_t inflight[$];
  fill_t   exp_q[$];

  int tests = 0, fails = 0;
  int cyc = 0, fill_cnt = 0;
  int gnt_pct, recv_pct, lat_max, cf_permille, err_pct;
  bit drain_on;
  int depth, epoch, first_off;
  bit stopped, req_pend;
  logic [63:0] next_addr, req_pend_addr;
  int req_pend_ep;

  function automatic logic [63:0] mem(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5C3_0F1E, ~a[31:0]} + (a * 64'h9E37_79B9_7F4A_7C15);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset(input bit boot_cf, input logic [63:0] boot_tgt);
    @(negedge g_clk);
    g_resetn = 1'b0;
    imem_gnt = 0; imem_recv = 0; imem_rdata = 0; imem_error = 0;
    cf_req = 0; cf_target = 0; buf_depth = 0; buf_drain_bytes = 0;
    @(negedge g_clk);
    cyc++;
    cf_req = boot_cf;
    cf_target = boot_tgt;
    inflight.delete();
    exp_q.delete();
    req_pend = 0; depth = 0; stopped = 0; epoch++;
    next_addr = {RESET_PC[63:3], 3'b000};
    first_off = int'(RESET_PC[2:1]);
    #2;
    check("rst_req", imem_req, 0);
    check("rst_ack", imem_ack, 1);
    check("rst_fill_en", buf_fill_en, 0);
    check("rst_strobes", {buf_fill_8, buf_fill_6, buf_fill_4, buf_fill_2}, 0);
    check("rst_data", buf_data, 0);
    check("rst_error", buf_error, 0);
    check("rst_cf_ack", cf_ack, boot_cf);
    check("rst_flush", buf_flush, boot_cf);
    if (boot_cf) begin
      epoch++;
      next_addr = {boot_tgt[63:3], 3'b000};
      first_off = int'(boot_tgt[2:1]);
    end
    g_resetn = 1'b1;
  endtask

  task automatic cycle(input bit force_cf, input logic [63:0] force_tgt);
    int drain, fill_bytes, cur_ep, off;
    bit exp_req, req;
    logic [63:0] addr;
    flight_t f;
    fill_t e;
    @(negedge g_clk);
    cyc++;
    imem_gnt = ($urandom_range(99) < gnt_pct);
    if (inflight.size() > 0 && inflight[0].ready <= cyc && $urandom_range(99) < recv_pct) begin
      imem_recv = 1; imem_rdata = mem(inflight[0].addr); imem_error = inflight[0].err;
    end else begin
      imem_recv = 0; imem_rdata = {$urandom, $urandom}; imem_error = 0;
    end
    cf_req = force_cf || ($urandom_range(999) < cf_permille);
    cf_target = force_cf ? force_tgt : ({$urandom, $urandom} & ~64'h1);
    drain = 0;
    if (drain_on) begin
      drain = 2 * $urandom_range(2);
      if (drain > depth) drain = depth;
    end
    buf_depth = 5'(depth);
    buf_drain_bytes = 3'(drain);
    #2;
    req = imem_req;
    addr = imem_addr;
    if (req_pend) begin
      check("req_held", req, 1);
      check("addr_held", addr, req_pend_addr);
      cur_ep = req_pend_ep;
    end else begin
      exp_req = !stopped && (depth - drain + 8 * (inflight.size() + 1) <= 12) && (inflight.size() < 2);
      check("req_issue", req, exp_req);
      if (req) begin
        check("req_addr", addr, next_addr);
        req_pend_addr = addr;
      end
      cur_ep = epoch;
    end
    check("cf_ack", cf_ack, cf_req);
    check("flush", buf_flush, cf_req);
    check("imem_ack", imem_ack, 1);
    fill_bytes = 0;
    if (imem_recv) begin
      f = inflight.pop_front();
      if (!cf_req && f.ep == epoch) begin
        off = first_off;
        e.size = 8 - 2 * off;
        e.data = mem(f.addr) >> (16 * off);
        e.err = f.err;
        exp_q.push_back(e);
        fill_cnt++;
        fill_bytes = e.size;
        first_off = 0;
        if (f.err) stopped = 1;
      end
    end
    if (req && imem_gnt) begin
      if (cur_ep == epoch) next_addr += 64'd8;
      f.addr = addr;
      f.ep = cur_ep;
      f.err = ($urandom_range(99) < err_pct);
      f.ready = cyc + 1 + $urandom_range(lat_max);
      inflight.push_back(f);
    end
    check("outstanding_max", inflight.size() <= 2, 1);
    req_pend = req && !imem_gnt;
    req_pend_ep = cur_ep;
    if (cf_req) begin
      depth = 0;
      epoch++;
      next_addr = {cf_target[63:3], 3'b000};
      first_off = int'(cf_target[2:1]);
      stopped = 0;
    end else begin
      depth = depth - drain + fill_bytes;
      check("buf_overflow", depth <= 12, 1);
    end
  endtask

  initial begin : monitor
    fill_t e;
    int act_size;
    logic [3:0] stb;
    forever begin
      @(negedge g_clk);
      #3;
      stb = {buf_fill_8, buf_fill_6, buf_fill_4, buf_fill_2};
      if (buf_fill_en !== 1'b1) begin
        check("idle_strobes", {60'd0, stb}, 0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_fill", buf_fill_en, 0);
      end else begin
        e = exp_q.pop_front();
        case (stb)
          4'b1000: act_size = 8;
          4'b0100: act_size = 6;
          4'b0010: act_size = 4;
          4'b0001: act_size = 2;
          default: act_size = 0;
        endcase
        check("fill_size", 64'(act_size), 64'(e.size));
        check("fill_data", buf_data, e.data);
        check("fill_error", buf_error, e.err);
      end
    end
  end

  initial begin : stimulus
    imem_gnt = 0; imem_recv = 0; imem_rdata = 0; imem_error = 0;
    cf_req = 0; cf_target = 0; buf_depth = 0; buf_drain_bytes = 0;
    epoch = 0;
    gnt_pct = 100; recv_pct = 100; lat_max = 0; drain_on = 0; cf_permille = 0; err_pct = 0;
    do_reset(0, 64'd0);
    repeat (8) cycle(0, 64'd0);
    drain_on = 1;
    repeat (12) cycle(0, 64'd0);
    cycle(1, 64'h1006);
    repeat (12) cycle(0, 64'd0);
    lat_max = 2;
    repeat (6) cycle(0, 64'd0);
    cycle(1, 64'h4000);
    repeat (10) cycle(0, 64'd0);
    gnt_pct = 0;
    repeat (3) cycle(0, 64'd0);
    cycle(1, 64'h2000);
    repeat (3) cycle(0, 64'd0);
    gnt_pct = 100;
    repeat (10) cycle(0, 64'd0);
    err_pct = 100;
    repeat (4) cycle(0, 64'd0);
    err_pct = 0;
    repeat (10) cycle(0, 64'd0);
    cycle(1, 64'h3002);
    repeat (10) cycle(0, 64'd0);
    cycle(1, 64'hFFFF_FFFF_FFFF_FFFA);
    repeat (10) cycle(0, 64'd0);
    do_reset(1, 64'h5004);
    repeat (10) cycle(0, 64'd0);
    gnt_pct = 60; recv_pct = 70; lat_max = 3; cf_permille = 30; err_pct = 2;
    for (int r = 0; r < 3; r++) begin
      repeat (1000) cycle(0, 64'd0);
      do_reset(r == 1, {$urandom, $urandom} & ~64'h1);
    end
    repeat (50) cycle(0, 64'd0);
    @(negedge g_clk);
    #4;
    check("leftover_fills", 64'(exp_q.size()), 0);
    check("fill_progress", fill_cnt >= 100, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
